// File: rtl/counter_sequencer.sv
// Rate-divided up-counter sequencer: IDLE -> RUN <-> PAUSE -> DONE.
// Ports: clock, resetn, start, pause, clear, limit, period -> count, tick, busy, done, state.
module counter_sequencer #(
  parameter int WIDTH = 4,
  parameter int DIV_W = 26
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic [WIDTH-1:0] limit,
  input  logic [DIV_W-1:0] period,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] per_q;
  logic [WIDTH-1:0] lim_q;
  logic [WIDTH-1:0] count_inc;
  logic             can_start;

  assign count_inc = count + WIDTH'(1);
  assign can_start = (state == IDLE) || (state == DONE);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      count <= '0;
      div_q <= '0;
      lim_q <= '0;
      per_q <= '0;
      tick  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      if (clear) begin
        state <= IDLE;
        count <= '0;
        div_q <= '0;
        busy  <= 1'b0;
      end else if (start && can_start) begin
        lim_q <= limit;
        per_q <= period;
        count <= '0;
        div_q <= period;
        // A zero terminal count has nothing to run.
        if (limit == '0) begin
          state <= DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end else begin
          state <= RUN;
          busy  <= 1'b1;
        end
      end else begin
        case (state)
          RUN: begin
            // Pause wins over a due step: nothing moves.
            if (pause) begin
              state <= PAUSE;
            end else if (div_q != '0) begin
              div_q <= div_q - DIV_W'(1);
            end else begin
              count <= count_inc;
              div_q <= per_q;
              tick  <= 1'b1;
              if (count_inc == lim_q) begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end
            end
          end
          // Resume edge only changes state;
          // divider continues next cycle.
          PAUSE: if (!pause) state <= RUN;
          IDLE:  ;
          DONE:  ;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer.
// Directed steps push expected outputs; a monitor checks after each edge.
module tb_counter_sequencer;

  localparam logic [1:0] SI = 2'b00;
  localparam logic [1:0] SR = 2'b01;
  localparam logic [1:0] SP = 2'b10;
  localparam logic [1:0] SD = 2'b11;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  limit = '0;
  logic [25:0] period = '0;
  logic [3:0]  count;
  logic        tick;
  logic        busy;
  logic        done;
  logic [1:0]  state;

  typedef struct {
    int         id;
    logic [1:0] st;
    logic [3:0] cnt;
    logic       tk;
    logic       bz;
    logic       dn;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   nstep = 0;

  counter_sequencer dut (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .pause  (pause),
    .clear  (clear),
    .limit  (limit),
    .period (period),
    .count  (count),
    .tick   (tick),
    .busy   (busy),
    .done   (done),
    .state  (state)
  );

  always #5 clock = ~clock;

  task automatic step(
    input logic rn, input logic cl,
    input logic st, input logic pa,
    input logic [3:0] lim,
    input logic [25:0] per,
    input logic [1:0] es, input logic [3:0] ec,
    input logic et, input logic eb, input logic ed
  );
    exp_t e;
    @(negedge clock);
    resetn = rn;
    clear  = cl;
    start  = st;
    pause  = pa;
    limit  = lim;
    period = per;
    e.id = nstep;
    e.st = es;
    e.cnt = ec;
    e.tk = et;
    e.bz = eb;
    e.dn = ed;
    nstep++;
    q.push_back(e);
  endtask

  // Plain cycle; limit/period wiggle to show they are ignored.
  task automatic run(
    input logic [1:0] es, input logic [3:0] ec,
    input logic et, input logic eb, input logic ed
  );
    step(1, 0, 0, 0, 4'd9, 26'd7, es, ec, et, eb, ed);
  endtask

  task automatic hold_pause(
    input logic [1:0] es, input logic [3:0] ec
  );
    step(1, 0, 0, 1, 4'd1, 26'd0, es, ec, 0, 1, 0);
  endtask

  always @(posedge clock) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if (state !== e.st || count !== e.cnt ||
          tick !== e.tk || busy !== e.bz ||
          done !== e.dn) begin
        failures++;
        $display(
          "FAIL step%0d: got st=%b cnt=%0d tk=%b bz=%b dn=%b want st=%b cnt=%0d tk=%b bz=%b dn=%b",
          e.id, state, count, tick, busy, done,
          e.st, e.cnt, e.tk, e.bz, e.dn);
      end
    end
  end

  initial begin
    int guard;
    // Reset, with other inputs active.
    step(0, 0, 1, 1, 4'd5, 26'd3, SI, 0, 0, 0, 0);
    step(0, 1, 1, 0, 4'd5, 26'd3, SI, 0, 0, 0, 0);
    run(SI, 0, 0, 0, 0);

    // limit=3 period=0: 1,2,3 then DONE.
    step(1, 0, 1, 0, 4'd3, 26'd0, SR, 0, 0, 1, 0);
    run(SR, 1, 1, 1, 0);
    run(SR, 2, 1, 1, 0);
    run(SD, 3, 1, 0, 1);
    run(SD, 3, 0, 0, 0);
    run(SD, 3, 0, 0, 0);

    // limit=2 period=4 from DONE: ticks at N+5, N+10.
    step(1, 0, 1, 0, 4'd2, 26'd4, SR, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) run(SR, 0, 0, 1, 0);
    run(SR, 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) run(SR, 1, 0, 1, 0);
    run(SD, 2, 1, 0, 1);
    run(SD, 2, 0, 0, 0);

    // limit=15 period=1, pause at count 5.
    step(1, 0, 1, 0, 4'd15, 26'd1, SR, 0, 0, 1, 0);
    for (int c = 1; c <= 5; c++) begin
      run(SR, 4'(c - 1), 0, 1, 0);
      run(SR, 4'(c), 1, 1, 0);
    end
    run(SR, 5, 0, 1, 0);
    // Divider is 0 here; pause must still block the step.
    for (int i = 0; i < 6; i++) hold_pause(SP, 5);
    run(SR, 5, 0, 1, 0);
    run(SR, 6, 1, 1, 0);
    run(SR, 6, 0, 1, 0);
    run(SR, 7, 1, 1, 0);
    // clear + start together in RUN at count 7.
    step(1, 1, 1, 0, 4'd3, 26'd0, SI, 0, 0, 0, 0);
    run(SI, 0, 0, 0, 0);

    // limit=0: straight to DONE, one done pulse.
    step(1, 0, 1, 0, 4'd0, 26'd5, SD, 0, 0, 0, 1);
    run(SD, 0, 0, 0, 0);
    run(SD, 0, 0, 0, 0);

    // Start held in RUN does not restart.
    step(1, 0, 1, 0, 4'd3, 26'd2, SR, 0, 0, 1, 0);
    step(1, 0, 1, 0, 4'd1, 26'd0, SR, 0, 0, 1, 0);
    step(1, 0, 1, 0, 4'd1, 26'd0, SR, 0, 0, 1, 0);
    step(1, 0, 1, 0, 4'd1, 26'd0, SR, 1, 1, 1, 0);
    step(1, 1, 0, 0, 4'd1, 26'd0, SI, 0, 0, 0, 0);

    // Reset during PAUSE.
    step(1, 0, 1, 0, 4'd5, 26'd3, SR, 0, 0, 1, 0);
    hold_pause(SP, 0);
    step(0, 0, 1, 1, 4'd5, 26'd3, SI, 0, 0, 0, 0);
    run(SI, 0, 0, 0, 0);

    // limit=15 period=0: no wrap, then restart.
    step(1, 0, 1, 0, 4'd15, 26'd0, SR, 0, 0, 1, 0);
    for (int c = 1; c < 15; c++) run(SR, 4'(c), 1, 1, 0);
    run(SD, 15, 1, 0, 1);
    run(SD, 15, 0, 0, 0);
    run(SD, 15, 0, 0, 0);
    step(1, 0, 1, 0, 4'd2, 26'd0, SR, 0, 0, 1, 0);
    run(SR, 1, 1, 1, 0);
    run(SD, 2, 1, 0, 1);
    run(SD, 2, 0, 0, 0);

    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      @(posedge clock);
      guard++;
    end
    #2;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
